// File: rtl/idex_pipl.sv
// ID/EX pipeline register: captures decoded operands and control each cycle.
// An all-zero register is a NOP bubble, so reset drains the stage safely.
module idex_pipl (
  input  logic         clock,
  input  logic         reset,
  output logic [120:0] idex_reg,
  input  logic [4:0]   ra,
  input  logic [4:0]   rb,
  input  logic [4:0]   wa,
  input  logic [31:0]  im_gen,
  input  logic [31:0]  rda,
  input  logic [31:0]  rdb,
  input  logic [3:0]   alu_op,
  input  logic         brnch,
  input  logic         mem_rd,
  input  logic         mem_to_rgs,
  input  logic         mem_wr,
  input  logic         alu_src,
  input  logic         reg_wr
);

  logic [120:0] idex_d;
  logic [120:0] idex_q;

  always_comb begin
    idex_d = {ra, rb, wa, im_gen, rda, rdb, alu_op,
              brnch, mem_rd, mem_to_rgs, mem_wr, alu_src, reg_wr};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign idex_reg = idex_q;

endmodule

// File: tb/tb_idex_pipl.sv
// Scoreboard bench for idex_pipl: directed corner cases then randomized traffic
// with asynchronous reset pulses, checked against a field-offset reference model.
module tb_idex_pipl;

  logic         clock;
  logic         reset;
  logic [120:0] idex_reg;
  logic [4:0]   ra, rb, wa;
  logic [31:0]  im_gen, rda, rdb;
  logic [3:0]   alu_op;
  logic         brnch, mem_rd, mem_to_rgs, mem_wr, alu_src, reg_wr;

  idex_pipl dut (
    .clock      (clock),
    .reset      (reset),
    .idex_reg   (idex_reg),
    .ra         (ra),
    .rb         (rb),
    .wa         (wa),
    .im_gen     (im_gen),
    .rda        (rda),
    .rdb        (rdb),
    .alu_op     (alu_op),
    .brnch      (brnch),
    .mem_rd     (mem_rd),
    .mem_to_rgs (mem_to_rgs),
    .mem_wr     (mem_wr),
    .alu_src    (alu_src),
    .reg_wr     (reg_wr)
  );

  logic clk_en;
  initial clock = 1'b0;
  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  typedef struct {
    string        name;
    logic [120:0] exp;
  } exp_t;

  exp_t         q[$];
  logic         mon_req;
  int           n_checks;
  int           n_fail;
  logic [120:0] model_q;

  // Reference model: each field placed at its documented bit offset.
  function automatic logic [120:0] pack_ref();
    logic [120:0] r;
    r = '0;
    r = r | (121'(ra)         << 116);
    r = r | (121'(rb)         << 111);
    r = r | (121'(wa)         << 106);
    r = r | (121'(im_gen)     << 74);
    r = r | (121'(rda)        << 42);
    r = r | (121'(rdb)        << 10);
    r = r | (121'(alu_op)     << 6);
    r = r | (121'(brnch)      << 5);
    r = r | (121'(mem_rd)     << 4);
    r = r | (121'(mem_to_rgs) << 3);
    r = r | (121'(mem_wr)     << 2);
    r = r | (121'(alu_src)    << 1);
    r = r | 121'(reg_wr);
    return r;
  endfunction

  // Monitor: samples shortly after each request and drains the scoreboard.
  initial begin
    forever begin
      @(mon_req);
      #1;
      while (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (idex_reg !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, idex_reg, e.exp);
        end
      end
    end
  end

  task automatic expect_now(input string nm, input logic [120:0] exp);
    exp_t e;
    e.name = nm;
    e.exp  = exp;
    q.push_back(e);
    mon_req = ~mon_req;
    fork
      begin wait (q.size() == 0); end
      begin #50; end
    join_any
    disable fork;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", nm, q.size());
      q.delete();
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clock);
    model_q = reset ? pack_ref() : '0;
    expect_now(nm, model_q);
  endtask

  task automatic tick_exp(input string nm, input logic [120:0] exp);
    @(posedge clock);
    model_q = reset ? pack_ref() : '0;
    expect_now(nm, exp);
  endtask

  task automatic set_all(input logic v);
    ra = {5{v}}; rb = {5{v}}; wa = {5{v}};
    im_gen = {32{v}}; rda = {32{v}}; rdb = {32{v}};
    alu_op = {4{v}};
    brnch = v; mem_rd = v; mem_to_rgs = v; mem_wr = v; alu_src = v; reg_wr = v;
  endtask

  task automatic set_rand();
    ra = 5'($urandom); rb = 5'($urandom); wa = 5'($urandom);
    im_gen = $urandom; rda = $urandom; rdb = $urandom;
    alu_op = 4'($urandom);
    brnch = 1'($urandom); mem_rd = 1'($urandom); mem_to_rgs = 1'($urandom);
    mem_wr = 1'($urandom); alu_src = 1'($urandom); reg_wr = 1'($urandom);
  endtask

  task automatic set_field_load();
    set_all(1'b0);
    ra = 5'd1; rb = 5'd2; wa = 5'd3;
    im_gen = 32'h10; rda = 32'hDEADBEEF; rdb = 32'h12345678;
    alu_op = 4'd2;
    mem_rd = 1'b1; mem_to_rgs = 1'b1; alu_src = 1'b1; reg_wr = 1'b1;
  endtask

  initial begin
    logic [120:0] onehot;
    logic [120:0] fl_exp;
    n_checks = 0;
    n_fail   = 0;
    mon_req  = 1'b0;
    clk_en   = 1'b0;
    model_q  = '0;

    set_all(1'b1);
    reset = 1'b0;
    #3;
    expect_now("rst_async", '0);

    clk_en = 1'b1;
    repeat (3) tick("rst_clocked");

    @(negedge clock);
    reset = 1'b1;
    set_field_load();
    fl_exp = {5'd1, 5'd2, 5'd3, 32'h10, 32'hDEADBEEF, 32'h12345678, 4'd2, 6'b011011};
    tick_exp("field_load", fl_exp);
    n_checks++;
    if (idex_reg[5:0] !== 6'b011011) begin
      n_fail++;
      $display("FAIL ctrl_bits: got %b expected 011011", idex_reg[5:0]);
    end

    set_rand();
    #2;
    expect_now("hold_between_edges", fl_exp);
    tick("hold_next_edge");

    @(negedge clock);
    set_all(1'b1);
    tick_exp("all_ones", '1);

    @(negedge clock);
    set_all(1'b0);
    ra = 5'b10000;
    onehot = '0; onehot[120] = 1'b1;
    tick_exp("walk_ra", onehot);

    @(negedge clock);
    set_all(1'b0);
    reg_wr = 1'b1;
    onehot = '0; onehot[0] = 1'b1;
    tick_exp("walk_reg_wr", onehot);

    @(negedge clock);
    set_all(1'b0);
    rdb = 32'd1;
    onehot = '0; onehot[10] = 1'b1;
    tick_exp("walk_rdb", onehot);

    @(negedge clock);
    set_field_load();
    tick("reload");
    @(negedge clock);
    #1;
    reset = 1'b0;
    model_q = '0;
    expect_now("rst_mid", '0);
    reset = 1'b1;
    set_rand();
    tick("rst_release");

    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      set_rand();
      if ($urandom_range(0, 15) == 0) begin
        #1;
        reset = 1'b0;
        model_q = '0;
        expect_now("rand_rst", '0);
        reset = 1'b1;
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idex_pipl.md
IDEX_PIPL -- requirements
Module: idex_pipl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 clock  input  1  rising-edge clock for the pipeline register.
REQ-003 reset  input  1  asynchronous active-low reset; 0 clears the register.
REQ-004 idex_reg  output  121  registered ID/EX bundle, packed per REQ-019.
REQ-005 ra  input  5  source register A index.
REQ-006 rb  input  5  source register B index.
REQ-007 wa  input  5  destination register index.
REQ-008 im_gen  input  32  sign-extended immediate from immediate generator.
REQ-009 rda  input  32  register file read data A.
REQ-010 rdb  input  32  register file read data B.
REQ-011 alu_op  input  4  ALU operation code.
REQ-012 brnch  input  1  branch control.
REQ-013 mem_rd  input  1  memory read enable.
REQ-014 mem_to_rgs  input  1  writeback select memory-vs-ALU.
REQ-015 mem_wr  input  1  memory write enable.
REQ-016 alu_src  input  1  ALU operand B select immediate-vs-rdb.
REQ-017 reg_wr  input  1  register file write enable.
REQ-018 The port order SHALL be: clock, reset, idex_reg, ra, rb, wa, im_gen, rda, rdb, alu_op, brnch, mem_rd, mem_to_rgs, mem_wr, alu_src, reg_wr.

Function
REQ-019 Packing (MSB..LSB) SHALL be: [120:116]=ra, [115:111]=rb, [110:106]=wa, [105:74]=im_gen, [73:42]=rda, [41:10]=rdb, [9:6]=alu_op, [5]=brnch, [4]=mem_rd, [3]=mem_to_rgs, [2]=mem_wr, [1]=alu_src, [0]=reg_wr.
REQ-020 On each rising clock edge with reset=1, idex_reg SHALL capture the packed concatenation of all inputs sampled at that edge.
REQ-021 Latency SHALL be exactly one clock: inputs at edge N appear on idex_reg after edge N and hold until edge N+1.
REQ-022 idex_reg SHALL be driven only from flops; there is no combinational input-to-output path.
REQ-023 Input changes between clock edges SHALL NOT affect idex_reg.
REQ-024 The block SHALL perform no field transformation: no sign extension, truncation or reordering beyond REQ-019.
REQ-025 Every bit SHALL update every enabled edge; there is no stall or flush input.

Reset
REQ-026 reset=0 SHALL force idex_reg to 121'b0 immediately, independent of clock.
REQ-027 While reset=0, clock edges SHALL be ignored and idex_reg SHALL stay 0.
REQ-028 After reset rises to 1, the first rising clock edge SHALL load the inputs per REQ-020.
REQ-029 An all-zero idex_reg SHALL encode a NOP bubble: all control bits 0, no register or memory write.

Verification
REQ-030 Reset: drive all inputs to ones, reset=0, no clock -> idex_reg == 0; toggle clock -> still 0.
REQ-031 Field load: ra=1, rb=2, wa=3, im_gen=0x10, rda=0xDEADBEEF, rdb=0x12345678, alu_op=2, mem_rd=1, mem_to_rgs=1, alu_src=1, reg_wr=1, others 0, one edge -> each slice of idex_reg per REQ-019 matches; [5:0]=6'b011011.
REQ-032 All-ones: every input at its maximum, one edge -> idex_reg == all 121 bits 1.
REQ-033 Walking one: set ra=5'b10000 only -> only bit 120 set; set reg_wr=1 only -> only bit 0 set; set rdb=1 only -> only bit 10 set.
REQ-034 Hold: load the REQ-031 values, change all inputs without a clock edge -> idex_reg unchanged; next edge -> new values.
REQ-035 Reset mid-operation: with a loaded non-zero value, pulse reset=0 between edges -> idex_reg == 0 at once; release, one edge -> current inputs appear.
